if_id_reg: RTL and testbench
============================

# if_id_reg

IF/ID pipeline register of the five-stage RV32I core. It captures the fetched instruction word and its PC at the end of IF and presents them to ID, where the immediate generator, register file and control unit consume them. It supports load-use stalls from the hazard detection unit, branch flushes from the ID-stage branch comparator and NOP insertion before `start_i`. It also tracks a valid bit so downstream logic can tell bubbles from real instructions.

## Interface
Parameters:
- `XLEN`, 32, datapath width for the PC and instruction buses.
- `NOP_INST`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`).

Ports:
- `clk_i`  input  1  core clock; all state updates on rising edge.
- `rst_i`  input  1  reset; asynchronous, active-high.
- `start_i`  input  1  core run enable; while low the stage loads bubbles.
- `pc_i`  input  XLEN  PC of the instruction in IF.
- `inst_i`  input  32  instruction word from instruction memory.
- `stall_i`  input  1  hold current contents (load-use hazard).
- `flush_i`  input  1  replace contents with a bubble (taken branch/jump).
- `pc_o`  output  XLEN  registered PC to ID.
- `inst_o`  output  32  registered instruction to ID, including immediate generation.
- `valid_o`  output  1  1 = `inst_o` is a real fetched instruction, 0 = bubble.
- `stall_cnt_o`  output  32  stall cycles counted (macro only).
- `flush_cnt_o`  output  32  flushes counted (macro only).

## Operation
- Three registers: `pc_q`, `inst_q`, `valid_q`. These drive `pc_o`, `inst_o` and `valid_o` directly, with no combinational path from inputs to outputs.
- Per rising edge, the first matching priority applies:
  1. `start_i`=0: load bubble (`inst_q`=NOP_INST, `pc_q`=0, `valid_q`=0).
  2. `flush_i`=1: load bubble. Flush wins over stall; a flush while stalled discards the held instruction.
  3. `stall_i`=1: hold all three registers unchanged.
  4. Otherwise: load `pc_i`, `inst_i`; set `valid_q`=1.
- A stall of N consecutive cycles presents the same `pc_o`/`inst_o` for N+1 cycles.
- A bubble is architecturally inert: the NOP encoding decodes as an I-type ALU op writing x0. ID needs no special-casing, and `valid_o` exists for tracing and counters.
- State is `valid_q` alone; effectively two states, BUBBLE (valid=0) and LOADED (valid=1). Transitions follow the priority list.

## Timing
- Reset, asynchronous assert: `inst_o`=NOP_INST, `pc_o`=0, `valid_o`=0 immediately. Counters are 0.
- Deassertion is sampled synchronously. The first capture occurs on the first rising edge with `rst_i`=0 and `start_i`=1.
- Reset mid-stall or mid-flush: reset dominates and all inputs are ignored while `rst_i`=1.
- Latency is 1 cycle from `inst_i`/`pc_i` to `inst_o`/`pc_o`.
- `stall_i` and `flush_i` are sampled on the same edge as the data. The hazard unit drives them combinationally in the same cycle.
- `inst_i` is don't-care during stall, flush or `start_i`=0 cycles.

## Configuration
- Macro `IF_ID_PERF_CNT_EN`.
- When defined:
  - `stall_cnt_o` increments on each edge where priority 3 applies.
  - `flush_cnt_o` increments on each edge where priority 2 applies.
  - Both counters saturate at 32'hFFFF_FFFF, with no wrap.
  - Both reset to 0 asynchronously and do not count while `start_i`=0.
- When undefined: both ports and both counters are absent, and all other behaviour is identical.

## Structure
- Shared package `cpu_pkg` holds `XLEN`, `NOP_INST`, and the opcode constants (`OP_IMM`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`) already used by ID-stage decode.
- One sub-module, `sat_counter` (32-bit, enable, async active-high reset, saturating). It is instantiated twice, only under `IF_ID_PERF_CNT_EN`.

## Test plan
- Assert `rst_i` mid-cycle with `inst_i`=32'h0050_0093 applied → `inst_o`=32'h0000_0013, `pc_o`=0 and `valid_o`=0 without waiting for a clock edge.
- `start_i`=1, pc_i=0x04, inst_i=0x0050_0093 → next cycle `pc_o`=0x04, `inst_o`=0x0050_0093, `valid_o`=1.
- Load at 0x08, then `stall_i`=1 for 2 cycles while `inst_i` changes to 0xDEAD_BEEF → `inst_o` and `pc_o` hold the 0x08 instruction for 3 cycles. With the macro defined, `stall_cnt_o`=2.
- `flush_i`=1 and `stall_i`=1 in the same cycle with a held instruction → next cycle `inst_o`=0x0000_0013 and `valid_o`=0. With the macro defined, `flush_cnt_o`=1 and `stall_cnt_o` is unchanged.
- Hold `start_i`=0 for 3 cycles with random `inst_i` → `valid_o` stays 0, `inst_o`=NOP_INST, and the counters stay 0.
- Macro defined, preload `stall_cnt_o` to 32'hFFFF_FFFE via force, then stall 3 cycles → the count reads 32'hFFFF_FFFF and holds.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core constants: datapath width, bubble encoding, decode opcodes.
// Also the IF/ID occupancy enum and a saturating-increment helper.
package cpu_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  localparam logic [6:0]  OP_IMM    = 7'b001_0011;
  localparam logic [6:0]  OP_LOAD   = 7'b000_0011;
  localparam logic [6:0]  OP_STORE  = 7'b010_0011;
  localparam logic [6:0]  OP_BRANCH = 7'b110_0011;

  typedef enum logic {
    BUBBLE = 1'b0,
    LOADED = 1'b1
  } if_id_state_e;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_id_reg_if.sv
// IF/ID bundle: fetch + hazard controls in, registered PC/inst out.
// Counter outputs exist only when IF_ID_PERF_CNT_EN is defined.
interface if_id_reg_if;
  import cpu_pkg::*;

  logic            start_i;
  logic [XLEN-1:0] pc_i;
  logic [31:0]     inst_i;
  logic            stall_i;
  logic            flush_i;
  logic [XLEN-1:0] pc_o;
  logic [31:0]     inst_o;
  logic            valid_o;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0]     stall_cnt_o;
  logic [31:0]     flush_cnt_o;
`endif

  modport master (
    output start_i, pc_i, inst_i,
    output stall_i, flush_i,
`ifdef IF_ID_PERF_CNT_EN
    input  stall_cnt_o, flush_cnt_o,
`endif
    input  pc_o, inst_o, valid_o
  );

  modport slave (
    input  start_i, pc_i, inst_i,
    input  stall_i, flush_i,
`ifdef IF_ID_PERF_CNT_EN
    output stall_cnt_o, flush_cnt_o,
`endif
    output pc_o, inst_o, valid_o
  );

endinterface

// File: rtl/if_id_reg_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
// Async active-high reset.
module sat_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] cnt_o
);
  import cpu_pkg::*;

  logic [31:0] cnt_q;

  // count enabled events, saturating
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     cnt_q <= '0;
    else if (en_i) cnt_q <= sat_inc(cnt_q);
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall, flush and pre-start bubbles.
// Define IF_ID_PERF_CNT_EN to add stall/flush event counters.
module if_id_reg #(
  parameter int          XLEN     = cpu_pkg::XLEN,
  parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input logic         clk_i,
  input logic         rst_i,
  if_id_reg_if.slave  bus
);
  import cpu_pkg::*;

  if_id_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;

  logic do_bubble;
  logic do_stall;
  logic do_load;

  // mutually exclusive actions; flush beats stall
  assign do_bubble = ~bus.start_i | bus.flush_i;
  assign do_stall  = ~do_bubble & bus.stall_i;
  assign do_load   = ~do_bubble & ~bus.stall_i;

  // next contents from the active action
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    unique case (1'b1)
      do_bubble: begin
        state_d = BUBBLE;
        pc_d    = '0;
        inst_d  = NOP_INST;
      end
      do_stall: begin
        state_d = state_q;
      end
      do_load: begin
        state_d = LOADED;
        pc_d    = bus.pc_i;
        inst_d  = bus.inst_i;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // stage registers, reset to a bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BUBBLE;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign bus.pc_o    = pc_q;
  assign bus.inst_o  = inst_q;
  assign bus.valid_o = (state_q == LOADED);

`ifdef IF_ID_PERF_CNT_EN
  logic stall_ev;
  logic flush_ev;

  assign stall_ev = do_stall;
  assign flush_ev = bus.start_i & bus.flush_i;

  sat_counter u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (stall_ev),
    .cnt_o (bus.stall_cnt_o)
  );

  sat_counter u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (flush_ev),
    .cnt_o (bus.flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: reference model, per-cycle compare, literal pins.
// Counter checks are active when IF_ID_PERF_CNT_EN is defined.
module tb_if_id_reg;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   armed = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  if_id_reg_if bus();

  if_id_reg dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_valid;
  longint      m_sc;
  longint      m_fc;

  // reference: stage contents after each edge, from the priority rules
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 0; m_inst = NOP_INST; m_valid = 0;
      m_sc = 0; m_fc = 0;
    end else if (!bus.start_i) begin
      m_pc = 0; m_inst = NOP_INST; m_valid = 0;
    end else if (bus.flush_i) begin
      m_pc = 0; m_inst = NOP_INST; m_valid = 0;
      if (m_fc < 64'hFFFF_FFFF) m_fc = m_fc + 1;
    end else if (bus.stall_i) begin
      if (m_sc < 64'hFFFF_FFFF) m_sc = m_sc + 1;
    end else begin
      m_pc = bus.pc_i; m_inst = bus.inst_i; m_valid = 1;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("pc_o", bus.pc_o, m_pc);
      chk("inst_o", bus.inst_o, m_inst);
      chk("valid_o", {31'b0, bus.valid_o}, {31'b0, m_valid});
`ifdef IF_ID_PERF_CNT_EN
      chk("stall_cnt_o", bus.stall_cnt_o, m_sc[31:0]);
      chk("flush_cnt_o", bus.flush_cnt_o, m_fc[31:0]);
`endif
    end
  end

  // apply one edge of inputs, return at the following negedge
  task automatic step(input bit st, input bit stl, input bit fl,
                      input logic [31:0] pc, input logic [31:0] inst);
    bus.start_i = st;
    bus.stall_i = stl;
    bus.flush_i = fl;
    bus.pc_i    = pc;
    bus.inst_i  = inst;
    @(negedge clk);
  endtask

  task automatic pin(input string tag, input logic [31:0] pc,
                     input logic [31:0] inst, input bit v);
    chk({tag, ".pc"}, bus.pc_o, pc);
    chk({tag, ".inst"}, bus.inst_o, inst);
    chk({tag, ".valid"}, {31'b0, bus.valid_o}, {31'b0, v});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 1; bus.stall_i = 0; bus.flush_i = 0;
    bus.pc_i = 32'h100; bus.inst_i = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    // async reset in mid-cycle must clear without an edge
    @(posedge clk);
    #3;
    rst = 1;
    bus.inst_i = 32'h0050_0093;
    #1;
    pin("async_rst", 32'h0, 32'h0000_0013, 0);
    @(negedge clk);
    rst = 0;
    armed = 1;

    step(1, 0, 0, 32'h04, 32'h0050_0093);
    pin("load4", 32'h04, 32'h0050_0093, 1);

    step(1, 0, 0, 32'h08, 32'h0010_0113);
    pin("stall_c1", 32'h08, 32'h0010_0113, 1);
    step(1, 1, 0, 32'h0C, 32'hDEAD_BEEF);
    pin("stall_c2", 32'h08, 32'h0010_0113, 1);
    step(1, 1, 0, 32'h10, 32'hDEAD_BEEF);
    pin("stall_c3", 32'h08, 32'h0010_0113, 1);
`ifdef IF_ID_PERF_CNT_EN
    chk("stall_cnt2", bus.stall_cnt_o, 32'd2);
`endif

    step(1, 1, 1, 32'h14, 32'hDEAD_BEEF);
    pin("flush_stall", 32'h0, 32'h0000_0013, 0);
`ifdef IF_ID_PERF_CNT_EN
    chk("flush_cnt1", bus.flush_cnt_o, 32'd1);
    chk("stall_keep", bus.stall_cnt_o, 32'd2);
`endif

    step(1, 1, 0, 32'h18, 32'h1111_1111);
    pin("stall_bubble", 32'h0, 32'h0000_0013, 0);
    step(1, 0, 0, 32'h1C, 32'h00A0_0093);
    pin("load1c", 32'h1C, 32'h00A0_0093, 1);

    // reset mid-stall/flush dominates, even across an edge
    bus.stall_i = 1; bus.flush_i = 1;
    #2;
    rst = 1;
    #1;
    pin("rst_mid", 32'h0, 32'h0000_0013, 0);
    bus.start_i = 1; bus.stall_i = 0; bus.flush_i = 0;
    bus.pc_i = 32'h50; bus.inst_i = 32'h0050_0093;
    @(negedge clk);
    pin("rst_hold", 32'h0, 32'h0000_0013, 0);
    rst = 0;

    for (int i = 0; i < 3; i++) begin
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom(), $urandom());
      pin("no_start", 32'h0, 32'h0000_0013, 0);
`ifdef IF_ID_PERF_CNT_EN
      chk("no_start.scnt", bus.stall_cnt_o, 32'd0);
      chk("no_start.fcnt", bus.flush_cnt_o, 32'd0);
`endif
    end

    step(1, 0, 0, 32'h20, 32'h0020_8133);
    pin("load20", 32'h20, 32'h0020_8133, 1);
    step(1, 0, 1, 32'h24, 32'hFFFF_FFFF);
    pin("flush_only", 32'h0, 32'h0000_0013, 0);
    step(1, 0, 0, 32'h28, 32'hFE00_0EE3);
    pin("load28", 32'h28, 32'hFE00_0EE3, 1);

`ifdef IF_ID_PERF_CNT_EN
    force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
    m_sc = 64'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.cnt_q;
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 32'h2C, 32'hDEAD_BEEF);
    chk("stall_sat", bus.stall_cnt_o, 32'hFFFF_FFFF);
    pin("sat_hold", 32'h28, 32'hFE00_0EE3, 1);
`endif

    step(1, 0, 0, 32'h30, 32'h0000_0013);
    armed = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
